branch_prediction_monitor: RTL and testbench

- Downstream consumer of the one-bit branch predictor.
- Taps the predictor's registered `prediction` and the same `branch_result` stream fed to the predictor, then time-aligns the two.
- Counts evaluated branches and mispredictions, tracks the consecutive-miss streak, and raises a thrash alarm for the branch unit's debug/CSR block.

---
 rtl/bpm_pkg.sv | 15 +
 rtl/branch_prediction_monitor_sat_counter.sv | 34 +++
 rtl/branch_prediction_monitor.sv | 157 +++++++++++++++
 tb/tb_branch_prediction_monitor.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bpm_pkg.sv
// Shared types and default configuration for the branch prediction monitor.
package bpm_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        ALARM   = 2'd1,
        RECOVER = 2'd2
    } bpm_state_e;

    localparam int DEF_COUNT_WIDTH      = 16;
    localparam int DEF_STREAK_WIDTH     = 4;
    localparam int DEF_STREAK_THRESHOLD = 4;
    localparam int DEF_RECOVER_HITS     = 2;

endpackage

// File: rtl/branch_prediction_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/branch_prediction_monitor.sv
// Aligns the predictor's output with the delayed branch outcome and keeps hit/miss statistics
// plus a thrash alarm. Optional counter snapshot registers are enabled by BPM_SNAPSHOT_EN.
module branch_prediction_monitor
    import bpm_pkg::*;
#(
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH,
    parameter int STREAK_WIDTH     = DEF_STREAK_WIDTH,
    parameter int STREAK_THRESHOLD = DEF_STREAK_THRESHOLD,
    parameter int RECOVER_HITS     = DEF_RECOVER_HITS
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef BPM_SNAPSHOT_EN
    input  logic                    snapshot,
    output logic [COUNT_WIDTH-1:0]  snap_total,
    output logic [COUNT_WIDTH-1:0]  snap_miss,
`endif
    input  logic                    branch_valid,
    input  logic                    branch_result,
    input  logic                    prediction,
    input  logic                    clear,
    output logic [COUNT_WIDTH-1:0]  total_count,
    output logic [COUNT_WIDTH-1:0]  miss_count,
    output logic [STREAK_WIDTH-1:0] miss_streak,
    output logic                    mispredict,
    output logic                    thrash_alarm
);

    localparam int REC_W = $clog2(RECOVER_HITS + 1);

    logic              vld_p1_q;
    logic              result_p1_q;
    logic              mispredict_q;
    logic              eval;
    logic              hit;
    logic              miss;
    logic [STREAK_WIDTH-1:0] streak_inc;
    bpm_state_e        state_q, state_d;
    logic [REC_W-1:0]  rec_q, rec_d;

    // Stage 1: hold the branch until the predictor's answer for it appears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            result_p1_q <= 1'b0;
        end else begin
            vld_p1_q    <= branch_valid;
            result_p1_q <= branch_result;
        end
    end

    // Stage 2: compare; a coinciding clear discards the evaluation.
    assign eval = vld_p1_q && !clear;
    assign hit  = eval && (prediction == result_p1_q);
    assign miss = eval && (prediction != result_p1_q);

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_total (
        .clk(clk), .rst(rst), .inc_i(eval), .clr_i(clear), .value_o(total_count)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_miss (
        .clk(clk), .rst(rst), .inc_i(miss), .clr_i(clear), .value_o(miss_count)
    );

    sat_counter #(.WIDTH(STREAK_WIDTH)) u_streak (
        .clk(clk), .rst(rst), .inc_i(miss), .clr_i(hit || clear), .value_o(miss_streak)
    );

    assign streak_inc = (miss_streak == '1) ? miss_streak : miss_streak + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_q <= 1'b0;
            state_q      <= NORMAL;
            rec_q        <= '0;
        end else begin
            mispredict_q <= miss;
            state_q      <= state_d;
            rec_q        <= rec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        if (clear) begin
            state_d = NORMAL;
            rec_d   = '0;
        end else begin
            unique case (state_q)
                NORMAL: begin
                    if (miss && (streak_inc >= STREAK_WIDTH'(STREAK_THRESHOLD))) begin
                        state_d = ALARM;
                    end
                end
                ALARM: begin
                    if (hit) begin
                        if (RECOVER_HITS == 1) begin
                            state_d = NORMAL;
                            rec_d   = '0;
                        end else begin
                            state_d = RECOVER;
                            rec_d   = REC_W'(1);
                        end
                    end
                end
                RECOVER: begin
                    if (miss) begin
                        state_d = ALARM;
                        rec_d   = '0;
                    end else if (hit) begin
                        if ((rec_q + 1'b1) >= REC_W'(RECOVER_HITS)) begin
                            state_d = NORMAL;
                            rec_d   = '0;
                        end else begin
                            rec_d = rec_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = NORMAL;
                    rec_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        thrash_alarm = (state_q == ALARM) || (state_q == RECOVER);
        mispredict   = mispredict_q;
    end

`ifdef BPM_SNAPSHOT_EN
    logic [COUNT_WIDTH-1:0] snap_total_q;
    logic [COUNT_WIDTH-1:0] snap_miss_q;
    logic [COUNT_WIDTH-1:0] total_upd;
    logic [COUNT_WIDTH-1:0] miss_upd;

    // Post-update values ignore clear so a snapshot taken with clear keeps the old totals.
    assign total_upd = (eval && (total_count != '1)) ? total_count + 1'b1 : total_count;
    assign miss_upd  = (miss && (miss_count != '1)) ? miss_count + 1'b1 : miss_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_total_q <= '0;
            snap_miss_q  <= '0;
        end else if (snapshot) begin
            snap_total_q <= total_upd;
            snap_miss_q  <= miss_upd;
        end
    end

    assign snap_total = snap_total_q;
    assign snap_miss  = snap_miss_q;
`endif

endmodule

// File: tb/tb_branch_prediction_monitor.sv
// Directed bench for branch_prediction_monitor (COUNT_WIDTH=4, threshold 4, recover 2).
module tb_branch_prediction_monitor;

    logic       clk;
    logic       rst;
    logic       branch_valid;
    logic       branch_result;
    logic       prediction;
    logic       clear;
    logic [3:0] total_count;
    logic [3:0] miss_count;
    logic [3:0] miss_streak;
    logic       mispredict;
    logic       thrash_alarm;

    int checks   = 0;
    int failures = 0;

    branch_prediction_monitor #(
        .COUNT_WIDTH(4), .STREAK_WIDTH(4), .STREAK_THRESHOLD(4), .RECOVER_HITS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .branch_valid(branch_valid), .branch_result(branch_result),
        .prediction(prediction), .clear(clear),
        .total_count(total_count), .miss_count(miss_count), .miss_streak(miss_streak),
        .mispredict(mispredict), .thrash_alarm(thrash_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit after it.
    task automatic cyc(input logic v, input logic r, input logic p, input logic c);
        branch_valid  = v;
        branch_result = r;
        prediction    = p;
        clear         = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int tot, input int mis, input int stk,
                           input int mp, input int al);
        chk({tag, ".total"},  int'(total_count),  tot);
        chk({tag, ".miss"},   int'(miss_count),   mis);
        chk({tag, ".streak"}, int'(miss_streak),  stk);
        chk({tag, ".mispr"},  int'(mispredict),   mp);
        chk({tag, ".alarm"},  int'(thrash_alarm), al);
    endtask

    initial begin
        rst = 1'b1;
        branch_valid = 1'b0; branch_result = 1'b0; prediction = 1'b0; clear = 1'b0;
        #2;
        chk_all("rst_hold", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        chk_all("idle", 0, 0, 0, 0, 0);

        // Alignment: branch result=1, predictor says 0 one cycle later.
        cyc(1, 1, 0, 0);
        chk_all("align_n", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("align_n1", 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 0);
        chk_all("align_pulse_end", 1, 1, 1, 0, 0);

        // Alarm entry: four consecutive misses.
        cyc(0, 0, 0, 1);
        chk_all("clr1", 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk_all("miss3", 3, 3, 3, 1, 0);
        cyc(0, 0, 0, 0);
        chk_all("miss4_alarm", 4, 4, 4, 1, 1);

        // Recovery: hit, miss, hit, hit.
        cyc(1, 1, 0, 0);
        chk_all("gap", 4, 4, 4, 0, 1);
        cyc(1, 1, 1, 0);
        chk_all("hit1_recover", 5, 4, 0, 0, 1);
        cyc(1, 1, 0, 0);
        chk_all("miss_back_alarm", 6, 5, 1, 1, 1);
        cyc(1, 1, 1, 0);
        chk_all("hit_recover", 7, 5, 0, 0, 1);
        cyc(0, 0, 1, 0);
        chk_all("hit2_normal", 8, 5, 0, 0, 0);

        // Saturation: 20 misses on 4-bit counters.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("saturate", 15, 15, 15, 1, 1);

        // Clear collides with a miss evaluation; the clear-cycle branch counts next edge.
        cyc(1, 1, 0, 0);
        chk_all("pre_clear", 15, 15, 15, 0, 1);
        cyc(1, 0, 0, 1);
        chk_all("clear_wins", 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("post_clear_eval", 1, 0, 0, 0, 0);

        // Async reset while in alarm.
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("alarm_again", 5, 4, 4, 1, 1);
        branch_valid = 1'b1; branch_result = 1'b1; prediction = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk_all("after_rst_no_eval", 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk_all("after_rst_eval", 1, 1, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
